// File: rtl/nand_page_prog_ctrl_if.sv
// Handshake bundle between the page program controller, its host and the NAND
// command/address/data writers and status reader; the controller takes the master side.
interface nand_page_prog_ctrl_if;
   logic        start;
   logic [27:0] addr;
   logic [12:0] data_len;
   logic        busy;
   logic        over;
   logic        fail;
   logic        timeout;

   logic        cmd_start;
   logic [7:0]  cmd_code;
   logic        cmd_over;

   logic        addr_start;
   logic [27:0] addr_out;
   logic        addr_over;

   logic        data_start;
   logic [12:0] data_cnt;
   logic        data_over;

   logic        stat_start;
   logic        stat_over;
   logic [7:0]  stat_data;

   modport master (
      input  start, addr, data_len, cmd_over, addr_over, data_over, stat_over, stat_data,
      output busy, over, fail, timeout, cmd_start, cmd_code, addr_start, addr_out,
             data_start, data_cnt, stat_start
   );

   modport slave (
      output start, addr, data_len, cmd_over, addr_over, data_over, stat_over, stat_data,
      input  busy, over, fail, timeout, cmd_start, cmd_code, addr_start, addr_out,
             data_start, data_cnt, stat_start
   );
endinterface

// File: rtl/nand_page_prog_ctrl.sv
// NAND page program sequencer (80h-addr-data-10h-tWB-RB-70h-status); first CMD_Start 1 cycle after Start,
// each step stalls until its *_Over; optional busy-wait timeout via NAND_PROG_TIMEOUT_EN.
module nand_page_prog_ctrl #(
   parameter int unsigned tWB_cnt     = 8,
   parameter logic [23:0] TIMEOUT_CNT = 24'hFFFFFF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rbn,
   nand_page_prog_ctrl_if.master io_bus
);

   typedef enum logic [3:0] {
      IDLE, CMD80, ADDR, DATA, CMD10, WAIT_WB, WAIT_RB, CMD70, STAT, DONE
   } state_t;

   localparam int              WB_W    = (tWB_cnt > 1) ? $clog2(tWB_cnt) : 1;
   localparam logic [WB_W-1:0] WB_LAST = WB_W'(tWB_cnt - 1);

   if (tWB_cnt < 1 || TIMEOUT_CNT == 24'd0) begin : g_bad_param
      $error("tWB_cnt and TIMEOUT_CNT must both be non-zero");
   end

   state_t          r_state;
   logic [WB_W-1:0] r_wb_cnt;
   logic            r_rb_meta;
   logic            r_rb_sync;
   logic            r_cmd_start;
   logic            r_addr_start;
   logic            r_data_start;
   logic            r_stat_start;
   logic            r_over;
   logic            r_fail;
   logic [7:0]      r_cmd_code;
   logic [27:0]     r_addr_out;
   logic [12:0]     r_data_cnt;

`ifdef NAND_PROG_TIMEOUT_EN
   localparam logic [23:0] TO_LAST = TIMEOUT_CNT - 24'd1;
   logic [23:0]     r_to_cnt;
   logic            r_timeout;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rb_meta <= 1'b0;
         r_rb_sync <= 1'b0;
      end else begin
         r_rb_meta <= i_rbn;
         r_rb_sync <= r_rb_meta;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_wb_cnt     <= '0;
         r_cmd_start  <= 1'b0;
         r_addr_start <= 1'b0;
         r_data_start <= 1'b0;
         r_stat_start <= 1'b0;
         r_over       <= 1'b0;
         r_fail       <= 1'b0;
         r_cmd_code   <= 8'h00;
         r_addr_out   <= '0;
         r_data_cnt   <= '0;
`ifdef NAND_PROG_TIMEOUT_EN
         r_to_cnt     <= '0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         // Start strobes and Over are single-cycle; they are raised only on the entering edge.
         r_cmd_start  <= 1'b0;
         r_addr_start <= 1'b0;
         r_data_start <= 1'b0;
         r_stat_start <= 1'b0;
         r_over       <= 1'b0;

         case (r_state)
            IDLE: begin
               if (io_bus.start) begin
                  r_addr_out  <= io_bus.addr;
                  r_data_cnt  <= io_bus.data_len;
                  r_fail      <= 1'b0;
`ifdef NAND_PROG_TIMEOUT_EN
                  r_timeout   <= 1'b0;
`endif
                  r_cmd_code  <= 8'h80;
                  r_cmd_start <= 1'b1;
                  r_state     <= CMD80;
               end
            end

            CMD80: begin
               if (io_bus.cmd_over) begin
                  r_cmd_code   <= 8'h00;
                  r_addr_start <= 1'b1;
                  r_state      <= ADDR;
               end
            end

            ADDR: begin
               if (io_bus.addr_over) begin
                  if (r_data_cnt == 13'd0) begin
                     r_cmd_code  <= 8'h10;
                     r_cmd_start <= 1'b1;
                     r_state     <= CMD10;
                  end else begin
                     r_data_start <= 1'b1;
                     r_state      <= DATA;
                  end
               end
            end

            DATA: begin
               if (io_bus.data_over) begin
                  r_cmd_code  <= 8'h10;
                  r_cmd_start <= 1'b1;
                  r_state     <= CMD10;
               end
            end

            CMD10: begin
               if (io_bus.cmd_over) begin
                  r_cmd_code <= 8'h00;
                  r_wb_cnt   <= '0;
                  r_state    <= WAIT_WB;
               end
            end

            WAIT_WB: begin
               if (r_wb_cnt == WB_LAST) begin
`ifdef NAND_PROG_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
                  r_state  <= WAIT_RB;
               end else begin
                  r_wb_cnt <= r_wb_cnt + 1'b1;
               end
            end

            WAIT_RB: begin
               if (r_rb_sync) begin
                  r_cmd_code  <= 8'h70;
                  r_cmd_start <= 1'b1;
                  r_state     <= CMD70;
               end
`ifdef NAND_PROG_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  r_fail    <= 1'b1;
                  r_timeout <= 1'b1;
                  r_over    <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_to_cnt <= r_to_cnt + 24'd1;
               end
`endif
            end

            CMD70: begin
               if (io_bus.cmd_over) begin
                  r_cmd_code   <= 8'h00;
                  r_stat_start <= 1'b1;
                  r_state      <= STAT;
               end
            end

            STAT: begin
               if (io_bus.stat_over) begin
                  r_fail  <= io_bus.stat_data[0];
                  r_over  <= 1'b1;
                  r_state <= DONE;
               end
            end

            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign io_bus.busy       = (r_state != IDLE);
   assign io_bus.over       = r_over;
   assign io_bus.fail       = r_fail;
   assign io_bus.cmd_start  = r_cmd_start;
   assign io_bus.cmd_code   = r_cmd_code;
   assign io_bus.addr_start = r_addr_start;
   assign io_bus.addr_out   = r_addr_out;
   assign io_bus.data_start = r_data_start;
   assign io_bus.data_cnt   = r_data_cnt;
   assign io_bus.stat_start = r_stat_start;
`ifdef NAND_PROG_TIMEOUT_EN
   assign io_bus.timeout    = r_timeout;
`else
   assign io_bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_nand_page_prog_ctrl.sv
// Bench for nand_page_prog_ctrl: sub-block responders, start-order scoreboard and vector table.
`timescale 1ns/1ps
module tb_nand_page_prog_ctrl;
   localparam int TWB    = 8;
   localparam int TO_CNT = 1000;
   localparam int RSP    = 5;

   typedef struct {
      logic [27:0] addr;
      logic [12:0] len;
      logic [7:0]  stat;
      int          rb_low;
      logic        exp_fail;
      int          exp_gap;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rbn = 1'b1;

   nand_page_prog_ctrl_if bus();

   nand_page_prog_ctrl #(.tWB_cnt(TWB), .TIMEOUT_CNT(24'(TO_CNT))) dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_rbn (rbn),
      .io_bus(bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [8:0]  exp_q[$];
   int          cyc = 0, over_cnt = 0, over_cyc = 0, c10_cyc = 0, c70_cyc = 0, data_cyc = 0;
   logic        c10_after_addr = 1'b0;
   bit          to_mode = 1'b0;

   logic        rsp_cmd = 1'b0, rsp_addr = 1'b0, rsp_data = 1'b0, rsp_stat = 1'b0, stray_data = 1'b0;
   int          c_cnt = 0, a_cnt = 0, d_cnt = 0, s_cnt = 0, rb_cnt = 0, rb_low_cfg = 0;
   bit          rb_hold = 1'b0;
   logic [7:0]  stat_dat = 8'h00;

   assign bus.cmd_over  = rsp_cmd;
   assign bus.addr_over = rsp_addr;
   assign bus.data_over = rsp_data | stray_data;
   assign bus.stat_over = rsp_stat;
   assign bus.stat_data = stat_dat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic ev(input logic [8:0] got);
      logic [8:0] want;
      want = 9'h1FF;
      if (exp_q.size() != 0) want = exp_q.pop_front();
      check("start_order", 32'(got), 32'(want));
   endtask

   // Monitor: every start strobe is scored against the expected command order.
   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cmd_start === 1'b1) begin
         ev({1'b0, bus.cmd_code});
         if (bus.cmd_code == 8'h10) begin
            c10_cyc        = cyc;
            c10_after_addr = bus.addr_over;
         end
         if (bus.cmd_code == 8'h70) c70_cyc = cyc;
      end
      if (bus.addr_start === 1'b1) ev(9'h101);
      if (bus.data_start === 1'b1) begin
         ev(9'h102);
         data_cyc = cyc;
      end
      if (bus.stat_start === 1'b1) ev(9'h103);
      if (bus.over === 1'b1) begin
         over_cnt++;
         over_cyc = cyc;
         if (!to_mode) check("over_lat", 32'(bus.stat_over), 32'd1);
      end
   end

   // Responders: Over RSP cycles after each start, RBn low rb_low_cfg cycles after CMD 10h.
   initial forever begin
      @(negedge clk);
      rsp_cmd = 1'b0; rsp_addr = 1'b0; rsp_data = 1'b0; rsp_stat = 1'b0;
      if (c_cnt > 0) begin c_cnt--; if (c_cnt == 0) rsp_cmd  = 1'b1; end
      if (a_cnt > 0) begin a_cnt--; if (a_cnt == 0) rsp_addr = 1'b1; end
      if (d_cnt > 0) begin d_cnt--; if (d_cnt == 0) rsp_data = 1'b1; end
      if (s_cnt > 0) begin s_cnt--; if (s_cnt == 0) rsp_stat = 1'b1; end
      if (rb_cnt > 0) rb_cnt--;
      if (bus.cmd_start === 1'b1) begin
         c_cnt = RSP;
         if (bus.cmd_code == 8'h10) rb_cnt = rb_low_cfg;
      end
      if (bus.addr_start === 1'b1) a_cnt = RSP;
      if (bus.data_start === 1'b1) d_cnt = RSP;
      if (bus.stat_start === 1'b1) s_cnt = RSP;
      rbn = !(rb_hold || rb_cnt > 0);
   end

   task automatic check_reset(input string tag);
      check({tag, "_busy"},  32'(bus.busy), 32'd0);
      check({tag, "_over"},  32'(bus.over), 32'd0);
      check({tag, "_fail"},  32'(bus.fail), 32'd0);
      check({tag, "_tmo"},   32'(bus.timeout), 32'd0);
      check({tag, "_strb"},  32'({bus.cmd_start, bus.addr_start, bus.data_start, bus.stat_start}), 32'd0);
      check({tag, "_code"},  32'(bus.cmd_code), 32'd0);
      check({tag, "_aout"},  32'(bus.addr_out), 32'd0);
      check({tag, "_dcnt"},  32'(bus.data_cnt), 32'd0);
   endtask

   task automatic wait_over(input int limit, output bit got);
      got = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.over === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_op(input vec_t v, input bit inject);
      int base;
      int cyc0;
      bit got;
      base = over_cnt;
      exp_q.push_back(9'h080);
      exp_q.push_back(9'h101);
      if (v.len != 13'd0) exp_q.push_back(9'h102);
      exp_q.push_back(9'h010);
      exp_q.push_back(9'h070);
      exp_q.push_back(9'h103);
      stat_dat   = v.stat;
      rb_low_cfg = v.rb_low;
      @(negedge clk);
      cyc0 = cyc;
      bus.start = 1'b1; bus.addr = v.addr; bus.data_len = v.len;
      @(negedge clk);
      bus.start = 1'b0; bus.addr = ~v.addr; bus.data_len = ~v.len;
      check("start_lat", 32'(bus.cmd_start), 32'd1);
      check("busy_run",  32'(bus.busy), 32'd1);
      check("addr_lat",  32'(bus.addr_out), 32'(v.addr));
      check("len_lat",   32'(bus.data_cnt), 32'(v.len));
      check("fail_clr",  32'(bus.fail), 32'd0);
      if (inject) begin
         got = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (c10_cyc > cyc0) begin got = 1'b1; break; end
         end
         check("c10_seen", 32'(got), 32'd1);
         repeat (20) @(negedge clk);
         bus.start = 1'b1; bus.addr = 28'h5A5A5A5; bus.data_len = 13'h7;
         @(negedge clk);
         bus.start = 1'b0;
         repeat (2) @(negedge clk);
         check("inj_addr", 32'(bus.addr_out), 32'(v.addr));
         check("inj_len",  32'(bus.data_cnt), 32'(v.len));
         check("inj_busy", 32'(bus.busy), 32'd1);
      end
      wait_over(3000, got);
      check("over_seen", 32'(got), 32'd1);
      if (!got) begin
         exp_q.delete();
         return;
      end
      check("done_fail", 32'(bus.fail), 32'(v.exp_fail));
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_tmo",  32'(bus.timeout), 32'd0);
      check("seq_done",  32'(exp_q.size()), 32'd0);
      if (v.len == 13'd0) check("c10_after_addr", 32'(c10_after_addr), 32'd1);
      if (v.exp_gap >= 0) check("wb_gap", 32'(c70_cyc - c10_cyc), 32'(v.exp_gap));
      @(negedge clk);
      check("over_pulse", 32'(bus.over), 32'd0);
      check("idle_busy",  32'(bus.busy), 32'd0);
      repeat (5) @(negedge clk);
      check("fail_hold",  32'(bus.fail), 32'(v.exp_fail));
      check("over_once",  32'(over_cnt), 32'(base + 1));
      check("addr_hold",  32'(bus.addr_out), 32'(v.addr));
   endtask

   initial begin
      vec_t vecs[5];
      int   base;
      int   d0;
      bit   got;

      bus.start = 1'b0; bus.addr = '0; bus.data_len = '0;
      vecs[0] = '{28'h0123456, 13'd2048, 8'hE0, 100, 1'b0, -1};
      vecs[1] = '{28'h0123456, 13'd2048, 8'hE1, 100, 1'b1, -1};
      vecs[2] = '{28'hABCDEF0, 13'd0,    8'hE0, 40,  1'b0, -1};
      vecs[3] = '{28'hFFFFFFF, 13'h1FFF, 8'hFE, 0,   1'b0, RSP + 1 + TWB + 1};
      vecs[4] = '{28'h0000001, 13'd1,    8'h01, 10,  1'b1, -1};

      repeat (3) @(negedge clk);
      check_reset("rst");
      rst = 1'b0;
      @(negedge clk);
      check_reset("post_rst");

      for (int i = 0; i < 5; i++) run_op(vecs[i], 1'b0);

      run_op(vecs[0], 1'b1);

      base = over_cnt;
      @(negedge clk);
      stray_data = 1'b1;
      @(negedge clk);
      stray_data = 1'b0;
      repeat (4) @(negedge clk);
      check("stray_busy", 32'(bus.busy), 32'd0);
      check("stray_over", 32'(over_cnt), 32'(base));
      check("stray_addr", 32'(bus.addr_out), 32'(vecs[0].addr));

      exp_q.push_back(9'h080); exp_q.push_back(9'h101); exp_q.push_back(9'h102);
      stat_dat = 8'hE0; rb_low_cfg = 100; d0 = data_cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.addr = 28'h0123456; bus.data_len = 13'd2048;
      @(negedge clk);
      bus.start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (data_cyc != d0) begin got = 1'b1; break; end
      end
      check("data_seen", 32'(got), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("mid_rst");
      check("rst_q", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (10) @(negedge clk);
      run_op(vecs[0], 1'b0);

`ifdef NAND_PROG_TIMEOUT_EN
      to_mode = 1'b1; rb_hold = 1'b1; rb_low_cfg = 100; base = over_cnt;
      exp_q.push_back(9'h080); exp_q.push_back(9'h101);
      exp_q.push_back(9'h102); exp_q.push_back(9'h010);
      @(negedge clk);
      bus.start = 1'b1; bus.addr = 28'h0ABCDEF; bus.data_len = 13'd16;
      @(negedge clk);
      bus.start = 1'b0;
      wait_over(2000, got);
      check("to_over", 32'(got), 32'd1);
      if (got) begin
         check("to_delay", 32'(over_cyc - c10_cyc), 32'(RSP + 1 + TWB + TO_CNT));
         check("to_fail",  32'(bus.fail), 32'd1);
         check("to_tmo",   32'(bus.timeout), 32'd1);
         check("to_no70",  32'(exp_q.size()), 32'd0);
      end
      exp_q.delete();
      @(negedge clk);
      rb_hold = 1'b0; to_mode = 1'b0;
      repeat (5) @(negedge clk);
      check("to_once", 32'(over_cnt), 32'(base + 1));
      check("to_hold", 32'(bus.timeout), 32'd1);
      run_op(vecs[0], 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nand_page_prog_ctrl.md
NAND_PAGE_PROG_CTRL -- requirements
Module: nand_page_prog_ctrl

Interface
REQ-001 Parameter tWB_cnt, default 8: CLK cycles waited after the 10h command before RBn is sampled.
REQ-002 Parameter TIMEOUT_CNT, default 24'hFFFFFF: maximum CLK cycles allowed in the busy wait (used only with REQ-030).
REQ-003 Clock and reset: CLK input 1, the single clock; RST input 1, reset that is synchronous and active-high.
REQ-004 Host ports:
- Start input 1: request pulse.
- ADDR input 28: page/column address.
- DATA_LEN input 13: byte count.
- Busy output 1: controller not idle.
- Over output 1: one-cycle done pulse.
- Fail output 1: program failed.
- TimeOut output 1: busy-wait timeout.
REQ-005 Command-writer ports: CMD_Start output 1; CMD_Code output 8; CMD_Over input 1.
REQ-006 Address-writer ports: ADDR_Start output 1; ADDR_Out output 28; ADDR_Over input 1.
REQ-007 Data-writer ports: DATA_Start output 1; DATA_Cnt output 13; DATA_Over input 1.
REQ-008 Status-reader ports: STAT_Start output 1; STAT_Over input 1; STAT_Data input 8.
REQ-009 Ready/busy port: RBn input 1, asynchronous NAND ready/busy, low = busy.

Function
REQ-010 States SHALL be, in this order: IDLE, CMD80, ADDR, DATA, CMD10, WAIT_WB, WAIT_RB, CMD70, STAT, DONE.
REQ-011 In IDLE, Start=1 SHALL do three things on the same edge: latch ADDR into ADDR_Out, latch DATA_LEN into DATA_Cnt, and enter CMD80.
REQ-012 Start SHALL be ignored in every state except IDLE; the latched ADDR_Out and DATA_Cnt SHALL stay stable until the next accepted Start.
REQ-013 In the first cycle of CMD80, ADDR, DATA, CMD10, CMD70 and STAT, the matching *_Start output SHALL pulse high for exactly one cycle.
REQ-014 Each *_Start output SHALL be registered and SHALL be low in every other cycle.
REQ-015 CMD_Code SHALL be 8'h80 in CMD80, 8'h10 in CMD10, 8'h70 in CMD70, and 8'h00 otherwise.
REQ-016 Each handshake state SHALL advance to the next state on the first cycle its own *_Over=1.
REQ-017 A *_Over input SHALL be ignored in any state it does not belong to.
REQ-018 DATA_LEN=0 SHALL skip DATA: ADDR goes to CMD10 and DATA_Start is never pulsed.
REQ-019 WAIT_WB SHALL hold for exactly tWB_cnt cycles, then enter WAIT_RB.
REQ-020 RBn SHALL pass through a 2-flop synchronizer.
REQ-021 WAIT_RB SHALL exit to CMD70 on the first cycle the synchronized RBn=1.
REQ-022 In STAT, on STAT_Over=1 the controller SHALL capture Fail <= STAT_Data[0] and enter DONE.
REQ-023 DONE SHALL last one cycle with Over=1, then return to IDLE.
REQ-024 Fail and TimeOut SHALL hold their value until the next accepted Start, which clears both.
REQ-025 Busy SHALL be 1 in every state except IDLE.
REQ-026 Cycle latency from accepted Start to the first CMD_Start pulse SHALL be 1 cycle.
REQ-027 Over SHALL be asserted 1 cycle after the edge on which STAT_Over is seen.

Reset
REQ-028 RST=1 at a rising CLK edge SHALL force IDLE from any state, including mid-handshake.
REQ-029 Reset values: all outputs 0, except CMD_Code=0, ADDR_Out=0 and DATA_Cnt=0; counters and synchronizer cleared; no *_Start pulse issued in the reset cycle or the cycle after.

Configuration
REQ-030 Macro NAND_PROG_TIMEOUT_EN, when defined:
- a 24-bit counter runs in WAIT_RB;
- when it reaches TIMEOUT_CNT, the controller sets Fail=1 and TimeOut=1 and goes to DONE, skipping CMD70 and STAT.
REQ-031 Macro NAND_PROG_TIMEOUT_EN, when undefined:
- WAIT_RB waits indefinitely;
- TimeOut is tied 0;
- no timeout counter is synthesized.

Verification
REQ-032 Basic program: ADDR=28'h0123456, DATA_LEN=2048, sub-blocks respond with Over 5 cycles after each Start, RBn low for 100 cycles, STAT_Data=8'hE0 -> start pulses occur in the order CMD(80h), ADDR, DATA, CMD(10h), CMD(70h), STAT; Over pulses once; Fail=0; ADDR_Out=28'h0123456.
REQ-033 Status fail: same stimulus as REQ-032 with STAT_Data=8'hE1 -> Over=1 and Fail=1; Fail stays 1 until the next Start.
REQ-034 Zero length: DATA_LEN=0 -> DATA_Start is never asserted; CMD 10h follows ADDR_Over by 1 cycle.
REQ-035 Ignored inputs: a Start pulse in WAIT_RB and a stray DATA_Over in IDLE -> no state change, ADDR_Out unchanged, no extra Over.
REQ-036 Reset mid-operation: RST=1 for 1 cycle during DATA -> next cycle is IDLE with Busy=0 and all outputs at reset values; a following Start runs a full sequence normally.
REQ-037 Timeout: with NAND_PROG_TIMEOUT_EN defined, TIMEOUT_CNT=1000 and RBn held low -> Over pulses 1000 cycles after WAIT_RB entry, with TimeOut=1 and Fail=1, and no CMD 70h is issued.
